// File: rtl/fixed_point_pkg.sv
// Shared fixed-point definitions: state encodings for the multiplier FSM and
// the thousandths-based fraction constants (also used by the divider).
package fixed_point_pkg;

  // Fraction fields are decimal thousandths held in a 10-bit field.
  localparam int unsigned FRAC_W     = 10;
  localparam int unsigned FRAC_SCALE = 1000;
  localparam int unsigned FRAC_MAX   = 999;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_INVALID = 3'd1,
    S_ZERO    = 3'd2,
    S_ACCUM   = 3'd3,
    S_NORM    = 3'd4,
    S_RESULT  = 3'd5
  } fx_state_t;

  // True when a thousandths fraction lies in 0..999.
  function automatic logic frac_legal(input logic [FRAC_W-1:0] frac);
    return frac <= FRAC_W'(FRAC_MAX);
  endfunction

endpackage

// File: rtl/fixed_mult_rtl.sv
// fixed_mult_rtl: multiplies a decimal fixed-point multiplicand (m + f/1000)
// by an unsigned integer b using repeated addition, then normalises the
// scaled accumulator back into an integer part p and a thousandths part pf.
//
// Ports:
//   clk    - clock, all state changes on rising edge
//   rst    - synchronous active-high reset
//   start  - operation request, sampled in IDLE (and in RESULT when holding)
//   m      - SIZE-bit integer part of the multiplicand
//   f      - 10-bit fraction of the multiplicand, thousandths, legal 0..999
//   b      - SIZE-bit unsigned multiplier
//   p      - 2*SIZE-bit integer part of the product
//   pf     - 10-bit fraction of the product, thousandths
//   valid  - high while p/pf carry a result
//   err    - one-cycle flag for an illegal fraction input
//   busy   - high while accumulating or normalising
//
// Build option: define FIXED_MULT_HOLD_RESULT_EN to hold the result (valid
// stays high) until the next start; otherwise valid is a one-cycle pulse.
module fixed_mult_rtl
  import fixed_point_pkg::*;
#(
  parameter int unsigned SIZE = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [SIZE-1:0]     m,
  input  logic [FRAC_W-1:0]   f,
  input  logic [SIZE-1:0]     b,
  output logic [2*SIZE-1:0]   p,
  output logic [FRAC_W-1:0]   pf,
  output logic                valid,
  output logic                err,
  output logic                busy
);

  // op = m*1000 + f fits SIZE+10 bits; acc = op*b fits 2*SIZE+10 bits.
  localparam int unsigned OP_W  = SIZE + FRAC_W;
  localparam int unsigned ACC_W = 2 * SIZE + FRAC_W;
  localparam int unsigned P_W   = 2 * SIZE;

  fx_state_t             state, state_n;
  logic [OP_W-1:0]       op_q, op_n, op_in;
  logic [SIZE-1:0]       b_q, b_n;
  logic [SIZE-1:0]       cnt_q, cnt_n;
  logic [ACC_W-1:0]      acc_q, acc_n;
  logic [P_W-1:0]        p_cnt_q, p_cnt_n;
  logic                  take;

  logic [P_W-1:0]        p_n;
  logic [FRAC_W-1:0]     pf_n;
  logic                  valid_n, err_n, busy_n;

  // Scaled multiplicand formed from the live inputs at capture time.
  assign op_in = OP_W'(m) * OP_W'(FRAC_SCALE) + OP_W'(f);

  // State, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      op_q    <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      p_cnt_q <= '0;
      p       <= '0;
      pf      <= '0;
      valid   <= 1'b0;
      err     <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= state_n;
      op_q    <= op_n;
      b_q     <= b_n;
      cnt_q   <= cnt_n;
      acc_q   <= acc_n;
      p_cnt_q <= p_cnt_n;
      p       <= p_n;
      pf      <= pf_n;
      valid   <= valid_n;
      err     <= err_n;
      busy    <= busy_n;
    end
  end

  // Next state, datapath updates and next output values.
  always_comb begin
    state_n = state;
    op_n    = op_q;
    b_n     = b_q;
    cnt_n   = cnt_q;
    acc_n   = acc_q;
    p_cnt_n = p_cnt_q;
    take    = 1'b0;

    case (state)
      S_IDLE: take = start;

      S_ACCUM: begin
        acc_n = acc_q + ACC_W'(op_q);
        cnt_n = cnt_q + SIZE'(1);
        if (cnt_n == b_q) state_n = S_NORM;
      end

      // Repeated subtraction of the scale yields the integer part in p_cnt
      // and leaves the thousandths remainder in acc.
      S_NORM: begin
        if (acc_q >= ACC_W'(FRAC_SCALE)) begin
          acc_n   = acc_q - ACC_W'(FRAC_SCALE);
          p_cnt_n = p_cnt_q + P_W'(1);
        end else begin
          state_n = S_RESULT;
        end
      end

      S_RESULT: begin
`ifdef FIXED_MULT_HOLD_RESULT_EN
        take = start;
`else
        state_n = S_IDLE;
`endif
      end

      S_ZERO, S_INVALID: state_n = S_IDLE;

      default: state_n = S_IDLE;
    endcase

    // Operand capture shares the IDLE dispatch rules wherever it happens.
    if (take) begin
      op_n    = op_in;
      b_n     = b;
      cnt_n   = '0;
      acc_n   = '0;
      p_cnt_n = '0;
      if (!frac_legal(f))                 state_n = S_INVALID;
      else if (b == '0 || op_in == '0)    state_n = S_ZERO;
      else                                state_n = S_ACCUM;
    end

    valid_n = (state_n == S_RESULT) || (state_n == S_ZERO);
    err_n   = (state_n == S_INVALID);
    busy_n  = (state_n == S_ACCUM) || (state_n == S_NORM);
    p_n     = (state_n == S_RESULT) ? p_cnt_n : '0;
    pf_n    = (state_n == S_RESULT) ? acc_n[FRAC_W-1:0] : '0;
  end

endmodule

// File: tb/tb_fixed_mult_rtl.sv
// Directed self-checking bench for fixed_mult_rtl with SIZE=4.
module tb_fixed_mult_rtl;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] m;
  logic [9:0] f;
  logic [3:0] b;
  logic [7:0] p;
  logic [9:0] pf;
  logic       valid;
  logic       err;
  logic       busy;

  int n_tests;
  int n_fail;

  fixed_mult_rtl #(.SIZE(4)) dut (
    .clk(clk), .rst(rst), .start(start), .m(m), .f(f), .b(b),
    .p(p), .pf(pf), .valid(valid), .err(err), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issues one start, scrambles inputs after capture, and returns the number
  // of edges from the start edge until valid or err (-1 on timeout).
  task automatic launch(input logic [3:0] mm, input logic [9:0] ff,
                        input logic [3:0] bb, output int lat, output bit busy_ok);
    @(negedge clk);
    m = mm; f = ff; b = bb; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; m = ~mm; f = 10'h3ff; b = ~bb;
    lat = -1;
    busy_ok = 1'b1;
    for (int i = 0; i <= 400; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      if (valid === 1'b1 || err === 1'b1) begin lat = i; break; end
      if (busy !== 1'b1) busy_ok = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b1; m = 4'd2; f = 10'd500; b = 4'd3;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if ({valid, err, busy} !== 3'b000 || p !== 8'd0 || pf !== 10'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: valid/err/busy=%b p=%0d pf=%0d, required 000 p=0 pf=0",
               {valid, err, busy}, p, pf);
    end
    @(negedge clk); rst = 1'b0; start = 1'b0;
  endtask

  task automatic test_mult(input string nm, input logic [3:0] mm, input logic [9:0] ff,
                           input logic [3:0] bb, input logic [7:0] ep, input logic [9:0] epf,
                           input int elat);
    int lat; bit bok;
    launch(mm, ff, bb, lat, bok);
    n_tests++;
    if (lat !== elat) begin
      n_fail++; $display("FAIL %s_latency: got %0d edges, required %0d", nm, lat, elat);
    end
    n_tests++;
    if (valid !== 1'b1 || err !== 1'b0 || p !== ep || pf !== epf) begin
      n_fail++;
      $display("FAIL %s_result: valid=%b err=%b p=%0d pf=%0d, required valid=1 err=0 p=%0d pf=%0d",
               nm, valid, err, p, pf, ep, epf);
    end
    n_tests++;
    if (!bok) begin
      n_fail++; $display("FAIL %s_busy: busy low during ACCUM/NORM, required high", nm);
    end
    @(posedge clk); #1;
    n_tests++;
`ifdef FIXED_MULT_HOLD_RESULT_EN
    if (valid !== 1'b1 || p !== ep || pf !== epf) begin
      n_fail++; $display("FAIL %s_hold: valid=%b p=%0d pf=%0d, required held result", nm, valid, p, pf);
    end
`else
    if (valid !== 1'b0 || p !== 8'd0 || pf !== 10'd0) begin
      n_fail++; $display("FAIL %s_pulse: valid=%b p=%0d pf=%0d, required 0 0 0", nm, valid, p, pf);
    end
`endif
  endtask

  task automatic test_zero(input string nm, input logic [3:0] mm, input logic [9:0] ff,
                           input logic [3:0] bb);
    int lat; bit bok;
    launch(mm, ff, bb, lat, bok);
    n_tests++;
    if (lat !== 0 || valid !== 1'b1 || err !== 1'b0 || busy !== 1'b0 || p !== 8'd0 || pf !== 10'd0) begin
      n_fail++;
      $display("FAIL %s: lat=%0d valid=%b err=%b busy=%b p=%0d pf=%0d, required lat=0 valid=1 rest 0",
               nm, lat, valid, err, busy, p, pf);
    end
    @(posedge clk); #1;
    n_tests++;
    if (valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL %s_one_cycle: valid=%b busy=%b, required 0 0", nm, valid, busy);
    end
  endtask

  task automatic test_invalid;
    int lat; bit bok;
    launch(4'd1, 10'd1000, 4'd2, lat, bok);
    n_tests++;
    if (lat !== 0 || err !== 1'b1 || valid !== 1'b0 || p !== 8'd0 || pf !== 10'd0) begin
      n_fail++;
      $display("FAIL invalid_err: lat=%0d err=%b valid=%b p=%0d pf=%0d, required 0 1 0 0 0",
               lat, err, valid, p, pf);
    end
    @(posedge clk); #1;
    n_tests++;
    if (err !== 1'b0 || valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL invalid_one_cycle: err=%b valid=%b busy=%b, required 0 0 0", err, valid, busy);
    end
  endtask

  task automatic test_reset_abort;
    int seen;
    @(negedge clk);
    m = 4'd5; f = 10'd250; b = 4'd4; start = 1'b1;
    @(posedge clk); #1;            // start edge, ACCUM follows
    start = 1'b0;
    @(posedge clk); #1;            // first add done, now in 2nd ACCUM cycle
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_tests++;
    if ({valid, err, busy} !== 3'b000 || p !== 8'd0 || pf !== 10'd0) begin
      n_fail++;
      $display("FAIL abort_outputs: valid/err/busy=%b p=%0d pf=%0d, required all 0", {valid, err, busy}, p, pf);
    end
    seen = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (valid === 1'b1 || busy === 1'b1) seen++;
    end
    n_tests++;
    if (seen !== 0) begin
      n_fail++; $display("FAIL abort_no_result: %0d active cycles after abort, required 0", seen);
    end
    test_mult("after_abort", 4'd5, 10'd250, 4'd4, 8'd21, 10'd0, 26);
  endtask

  // A start with different operands during NORM must not disturb the result.
  task automatic test_start_ignored;
    int lat;
    @(negedge clk);
    m = 4'd2; f = 10'd500; b = 4'd3; start = 1'b1;
    @(posedge clk); #1;            // edge 0
    start = 1'b0;
    repeat (5) @(posedge clk);     // edge 5: in NORM
    #1;
    m = 4'd1; f = 10'd0; b = 4'd1; start = 1'b1;
    @(posedge clk); #1;            // edge 6 samples the stray start
    start = 1'b0;
    lat = -1;
    for (int i = 7; i <= 40; i++) begin
      @(posedge clk); #1;
      if (valid === 1'b1) begin lat = i; break; end
    end
    n_tests++;
    if (lat !== 11 || p !== 8'd7 || pf !== 10'd500) begin
      n_fail++;
      $display("FAIL norm_start_ignored: lat=%0d p=%0d pf=%0d, required lat=11 p=7 pf=500", lat, p, pf);
    end
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
`ifdef FIXED_MULT_HOLD_RESULT_EN
    if (valid !== 1'b1 || p !== 8'd7 || pf !== 10'd500) begin
      n_fail++; $display("FAIL norm_hold: valid=%b p=%0d pf=%0d, required 1 7 500", valid, p, pf);
    end
`else
    if (valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL norm_after: valid=%b busy=%b, required 0 0", valid, busy);
    end
`endif
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b0; start = 1'b0; m = '0; f = '0; b = '0;
    test_reset();
    test_mult("basic", 4'd2, 10'd500, 4'd3, 8'd7, 10'd500, 11);
    test_mult("max", 4'd15, 10'd999, 4'd15, 8'd239, 10'd985, 255);
    test_mult("b_one_p_zero", 4'd0, 10'd999, 4'd1, 8'd0, 10'd999, 2);
    test_mult("small", 4'd1, 10'd1, 4'd2, 8'd2, 10'd2, 5);
    test_zero("zero_b", 4'd3, 10'd333, 4'd0);
    test_zero("zero_op", 4'd0, 10'd0, 4'd5);
    test_invalid();
    test_reset_abort();
    test_start_ignored();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fixed_mult_rtl.md
FIXED_MULT_RTL -- requirements
Module: fixed_mult_rtl

Interface
REQ-001 SHALL provide parameter SIZE, default 4, the width of the integer operands m and b.
REQ-002 SHALL provide port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 SHALL provide port rst, input, 1 bit, reset, synchronous and active-high.
REQ-004 SHALL provide port start, input, 1 bit, an operation request sampled only in IDLE.
REQ-005 SHALL provide port m, input, SIZE bits, the integer part of the fixed-point multiplicand.
REQ-006 SHALL provide port f, input, 10 bits, the fraction of the multiplicand in thousandths; legal range 0..999.
REQ-007 SHALL provide port b, input, SIZE bits, the unsigned integer multiplier.
REQ-008 SHALL provide port p, output, 2*SIZE bits, the integer part of the product.
REQ-009 SHALL provide port pf, output, 10 bits, the fraction of the product in thousandths (0..999).
REQ-010 SHALL provide port valid, output, 1 bit, high while p/pf carry a result.
REQ-011 SHALL provide port err, output, 1 bit, high for an illegal fraction input.
REQ-012 SHALL provide port busy, output, 1 bit, high in ACCUM and NORM.

Function
REQ-013 SHALL compute p + pf/1000 = (m + f/1000) * b exactly; no rounding is ever required.
REQ-014 SHALL implement states IDLE, INVALID, ZERO, ACCUM, NORM and RESULT.
REQ-015 SHALL, in IDLE with start=1, capture m, f and b into registers and compute op = m*1000 + f (SIZE+10 bits); the accumulator acc (2*SIZE+10 bits), the add counter and p_cnt are cleared.
REQ-016 SHALL transition from IDLE: f>999 goes to INVALID; otherwise b==0 or op==0 goes to ZERO; otherwise to ACCUM.
REQ-017 SHALL, in ACCUM, perform acc += op once per cycle and go to NORM on the cycle the b-th add is performed.
REQ-018 SHALL, in NORM, do acc -= 1000 and p_cnt += 1 each cycle while acc >= 1000; when acc < 1000, go to RESULT.
REQ-019 SHALL, in RESULT, drive valid=1, p=p_cnt and pf=acc[9:0].
REQ-020 SHALL raise valid exactly b + p + 1 rising edges after the edge that sampled start.
REQ-021 SHALL, in ZERO, drive valid=1, p=0 and pf=0 for one cycle, then return to IDLE.
REQ-022 SHALL, in INVALID, drive err=1, valid=0, p=0 and pf=0 for one cycle, then return to IDLE.
REQ-023 SHALL drive p=0, pf=0, valid=0 and err=0 in IDLE, ACCUM and NORM; outputs are never X or Z.
REQ-024 SHALL ignore start outside IDLE; input changes after capture do not affect the operation in flight.

Reset
REQ-025 SHALL, when rst=1 at a clock edge, set state=IDLE, clear all datapath registers and drive valid=0, err=0, busy=0, p=0 and pf=0.
REQ-026 SHALL give rst priority over start and abort any operation in flight mid-ACCUM or mid-NORM without producing a result.

Configuration
REQ-027 SHALL, with FIXED_MULT_HOLD_RESULT_EN undefined, return from RESULT to IDLE after one cycle, so valid is a one-cycle pulse.
REQ-028 SHALL, with FIXED_MULT_HOLD_RESULT_EN defined, hold RESULT with valid=1 and p/pf stable until start=1; a start in RESULT captures operands and follows the IDLE transition rules of REQ-016 on the same edge.

Structure
REQ-029 SHALL take the state encodings and the constants FRAC_SCALE=1000 and FRAC_MAX=999 from shared package fixed_point_pkg, which the divider also uses.
REQ-030 SHALL be a single module with no sub-module; the FSM and datapath are small enough to share one next-state block.

Verification (SIZE=4)
REQ-031 SHALL cover: m=2, f=500, b=3 -> p=7, pf=500; valid rises 11 edges after the start edge.
REQ-032 SHALL cover: m=15, f=999, b=15 -> p=239, pf=985; busy is high throughout ACCUM and NORM.
REQ-033 SHALL cover: m=3, f=333, b=0 -> ZERO, a one-cycle valid with p=0 and pf=0; also m=0, f=0, b=5 -> the same.
REQ-034 SHALL cover: m=1, f=1000, b=2 -> err high for one cycle, valid stays 0, back in IDLE on the next cycle.
REQ-035 SHALL cover: rst=1 on the 2nd ACCUM cycle of m=5, f=250, b=4 -> IDLE and all outputs 0 on the next cycle; a following start with m=5, f=250, b=4 -> p=21, pf=0.
REQ-036 SHALL cover: start pulsed during NORM -> ignored and the in-flight result is unchanged; with FIXED_MULT_HOLD_RESULT_EN defined, valid stays high until the next start.
